dmem_responder: RTL
===================

# dmem_responder

Multi-cycle data-memory responder for the single-cycle CPU's load/store port. It accepts the CPU's `MemRead`/`MemWrite` strobes, address (ALU result) and store data (RT register value), and services each access over a parameterised latency. During that time it holds `stall_o` high so the CPU freezes its PC and register write-back. It replaces the zero-latency data memory and lets the core run against slow-memory timing.

## Interface

- `DEPTH_WORDS`, default 32: number of 32-bit words of storage; legal range 1..1024.
- `LATENCY`, default 3: cycles from request acceptance to completion, counting the acceptance cycle; legal range 1..15.

- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `MemRead_i` input 1: load request from Control.
- `MemWrite_i` input 1: store request from Control.
- `addr_i` input 32: byte address from the ALU.
- `Writedata_i` input 32: store data from the register file RT port.
- `Readdata_o` output 32: load result to the write-back mux; registered.
- `stall_o` output 1: CPU must hold PC and suppress register write while high.
- `ready_o` output 1: one-cycle pulse marking completion; `Readdata_o` is valid in that cycle.
- `err_o` output 1: one-cycle pulse with `ready_o` when the access was illegal.

## Operation

- FSM states:
  - IDLE: no access in progress.
  - BUSY: access captured, latency counting.
  - DONE: completion cycle.
- IDLE:
  - Request means `MemRead_i | MemWrite_i`.
  - On a request: `stall_o`=1 combinationally in the same cycle.
  - At the edge: latch op, `addr_i` and `Writedata_i`; load the counter with LATENCY-1.
  - Next state: BUSY if LATENCY>1, else DONE.
- BUSY:
  - `stall_o`=1.
  - Counter decrements each cycle; move to DONE on the edge where the counter is 1.
  - Inputs are ignored; only latched values are used.
- DONE:
  - `stall_o`=0, `ready_o`=1.
  - Read: `Readdata_o` = mem[addr[log2(DEPTH_WORDS)+1:2]].
  - Write: the memory word is updated at the edge leaving DONE.
  - Next state is always IDLE.
  - Because stall drops in DONE, the CPU retires the instruction at that edge. Any request seen in the following IDLE cycle belongs to a new instruction.
- Illegal access (checked on latched values):
  - addr[1:0] != 0 (misaligned), addr[31:2] >= DEPTH_WORDS (out of range), or both MemRead and MemWrite set.
  - Full latency still elapses.
  - In DONE: `err_o`=1, no memory write, `Readdata_o` loads 0.
- `Readdata_o` holds its value between loads. Stores and errors do not change it, except that an error loads 0.
- Memory contents are not initialised by reset and are retained across reset. The bench preloads them via hierarchical access.

## Timing

- Reset values: state IDLE, counter 0, `Readdata_o`=0, `stall_o`=0 (when no request is present), `ready_o`=0, `err_o`=0.
- Request accepted in cycle t: `stall_o`=1 for cycles t..t+LATENCY-1; `ready_o`=1 and `stall_o`=0 in cycle t+LATENCY.
- LATENCY=1: stall for exactly one cycle (t); DONE at t+1.
- Back-to-back accesses: a new request in the cycle after DONE is accepted immediately. Minimum spacing between completions is LATENCY+1 cycles.
- Read-after-write: a load accepted after a store's DONE cycle returns the stored value.
- Reset asserted mid-access (BUSY or DONE): FSM returns to IDLE at that edge; a pending store is discarded and memory is unchanged; `Readdata_o` is cleared to 0.
- Reset asserted together with a request: the request is ignored.
- `stall_o` is the only combinational output; it depends on state and, in IDLE, on the request inputs.

## Test plan

- Reset, then a single load with LATENCY=3, mem[2]=32'hDEADBEEF, addr 32'h8: `stall_o` is high for 3 cycles, then in the 4th cycle `ready_o`=1 and `Readdata_o`=32'hDEADBEEF; `err_o`=0.
- Store 32'h12345678 to addr 32'h10, then a load from 32'h10 in the next IDLE cycle: the load returns 32'h12345678; mem[4] changes only at the edge leaving the store's DONE.
- Misaligned load at addr 32'h6, and a store to addr 32'h80 with DEPTH_WORDS=32: each completes after LATENCY cycles with `err_o`=1 and `Readdata_o`=0; mem[31] is untouched.
- MemRead_i and MemWrite_i both high, addr 32'h4: `err_o`=1 in DONE and mem[1] is unchanged.
- Reset pulsed during the 2nd BUSY cycle of a store of 32'hAAAA5555 to addr 32'h0: next cycle is IDLE with `stall_o`=0 and `Readdata_o`=0; mem[0] keeps its old value.
- LATENCY=1 with three back-to-back loads of addrs 0, 4, 8: the `stall_o`/`ready_o` pattern repeats every 2 cycles and each load returns the correct word.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data-memory responder for the CPU load/store port. A load or
//   store is captured in IDLE, counted down over LATENCY cycles while the CPU
//   is stalled, and completed in a single DONE cycle that pulses ready_o.
//   Misaligned, out-of-range or read+write accesses finish with err_o and
//   leave memory untouched. Memory contents are not reset.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words of storage (1..1024)
//   LATENCY     : cycles from acceptance to completion, counting the
//                 acceptance cycle (1..15)
//
// Ports
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   MemRead_i   : load request
//   MemWrite_i  : store request
//   addr_i      : byte address
//   Writedata_i : store data
//   Readdata_o  : registered load result, valid while ready_o is high
//   stall_o     : CPU must hold PC and suppress write-back (combinational)
//   ready_o     : one-cycle completion pulse
//   err_o       : one-cycle pulse with ready_o for an illegal access
module dmem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] Writedata_i,
    output logic [31:0] Readdata_o,
    output logic        stall_o,
    output logic        ready_o,
    output logic        err_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      cnt;
    logic            rd_q;
    logic            wr_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            req;
    logic            accept;
    logic            enter_done;
    logic            acc_rd;
    logic            acc_wr;
    logic [31:0]     acc_addr;
    logic [AW-1:0]   acc_idx;
    logic            acc_illegal;

    function automatic logic is_illegal(input logic rd, input logic wr,
                                        input logic [31:0] addr);
        return (addr[1:0] != 2'b00) ||
               ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) ||
               (rd && wr);
    endfunction

    assign req    = MemRead_i | MemWrite_i;
    assign accept = (state == IDLE) && req;

    // With LATENCY=1 the edge that accepts the access is also the edge that
    // enters DONE, so the completion path must look at the live inputs then
    // and at the latched copies otherwise.
    assign acc_rd      = (state == IDLE) ? MemRead_i  : rd_q;
    assign acc_wr      = (state == IDLE) ? MemWrite_i : wr_q;
    assign acc_addr    = (state == IDLE) ? addr_i     : addr_q;
    assign acc_idx     = acc_addr[AW+1:2];
    assign acc_illegal = is_illegal(acc_rd, acc_wr, acc_addr);
    assign enter_done  = (state_next == DONE);

    // State register, counter and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            Readdata_o <= 32'd0;
            ready_o    <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state   <= state_next;
            ready_o <= enter_done;
            err_o   <= enter_done && acc_illegal;
            if (accept) begin
                cnt <= 4'(LATENCY - 1);
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_done) begin
                if (acc_illegal) begin
                    Readdata_o <= 32'd0;
                end else if (acc_rd) begin
                    Readdata_o <= mem[acc_idx];
                end
            end
        end
    end

    // Access capture; only meaningful while the FSM is outside IDLE
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rd_q    <= MemRead_i;
            wr_q    <= MemWrite_i;
            addr_q  <= addr_i;
            wdata_q <= Writedata_i;
        end
    end

    // Store commits on the edge leaving DONE; err_o already flags illegal
    // accesses in that cycle, and a reset on that edge discards the store.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state == DONE) && wr_q && !err_o) begin
            mem[addr_q[AW+1:2]] <= wdata_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = (LATENCY > 1) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (cnt == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: stall rises in the accepting cycle itself
    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = req;
            BUSY:    stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

endmodule
